// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier that returns the low WIDTH bits of A*B.
// Every operation takes exactly WIDTH RUN cycles, then the result is held in DONE until the consumer takes it.
module mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] P,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  // One shift-add step; the sum wraps naturally to WIDTH bits.
  always_comb begin
    acc_sum   = b_reg[0] ? (acc + a_reg) : acc;
    last_step = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags depend on the state register alone.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            P <= acc_sum;
          end
        end
        default: begin
          a_reg <= a_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: transaction-level timing model plus directed literal checks.
// A second WIDTH=2 instance is swept exhaustively over all operand pairs.
module tb_mul_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] P;
  logic         busy;

  logic         rst2;
  logic         in_valid2;
  logic         in_ready2;
  logic [1:0]   A2;
  logic [1:0]   B2;
  logic         out_valid2;
  logic         out_ready2;
  logic [1:0]   P2;
  logic         busy2;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;
  bit w2_done    = 1'b0;

  // Transaction model: an accepted pair produces its product W edges later and holds until taken.
  int           edge_no     = 0;
  bit           m_active    = 1'b0;
  int           m_done_edge = 0;
  logic [W-1:0] m_p         = '0;
  logic [W-1:0] m_res       = '0;
  int           m_accepts   = 0;
  int           dut_accepts = 0;
  bit           exp_ir, exp_ov, exp_busy;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .busy(busy)
  );

  mul_seq_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(A2), .B(B2), .out_valid(out_valid2), .out_ready(out_ready2),
    .P(P2), .busy(busy2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ordy);
    in_valid  = v;
    A         = a;
    B         = b;
    out_ready = ordy;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      m_active = 1'b0;
      m_p      = '0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active    = 1'b1;
        m_done_edge = edge_no + W;
        m_res       = W'((32'(A) * 32'(B)) % (1 << W));
        m_accepts++;
      end
    end else if (edge_no == m_done_edge) begin
      m_p = m_res;
    end else if (edge_no > m_done_edge && out_ready) begin
      m_active = 1'b0;
    end
    exp_ir   = !m_active;
    exp_ov   = m_active && (edge_no >= m_done_edge);
    exp_busy = m_active && (edge_no < m_done_edge);
  end

  always @(negedge clk) begin
    if (in_ready && in_valid && !rst) dut_accepts++;
    if (chk_en) begin
      checkOutput("in_ready", in_ready, exp_ir);
      checkOutput("out_valid", out_valid, exp_ov);
      checkOutput("busy", busy, exp_busy);
      checkOutput("P", P, m_p);
    end
  end

  task automatic runOne(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp_p,
                        input string name);
    applyStimulus(1'b1, a, b, 1'b1);
    stepEdge();
    applyStimulus(1'b0, W'($urandom), W'($urandom), 1'b1);
    repeat (W - 1) stepEdge();
    checkOutput({name, "_not_early"}, out_valid, 1'b0);
    stepEdge();
    checkOutput({name, "_valid"}, out_valid, 1'b1);
    checkOutput({name, "_P"}, P, exp_p);
    stepEdge();
    checkOutput({name, "_idle"}, in_ready, 1'b1);
    checkOutput({name, "_P_kept"}, P, exp_p);
  endtask

  initial begin
    int acc0;
    int dacc0;
    rst = 1'b1;
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b0);
    stepEdge();
    chk_en = 1'b1;
    stepEdge();
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_P", P, 8'd0);
    rst = 1'b0;

    runOne(8'd3, 8'd5, 8'd15, "mul_3x5");
    runOne(8'd255, 8'd255, 8'd1, "mul_255x255");
    runOne(8'd0, 8'd200, 8'd0, "mul_0x200");

    // Consumer stalls for five cycles while the inputs wiggle.
    applyStimulus(1'b1, 8'd7, 8'd9, 1'b0);
    stepEdge();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    repeat (W) stepEdge();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", out_valid, 1'b1);
      checkOutput("stall_P", P, 8'd63);
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0);
      stepEdge();
    end
    checkOutput("stall_end_P", P, 8'd63);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
    stepEdge();
    checkOutput("stall_release_idle", in_ready, 1'b1);
    checkOutput("stall_release_P", P, 8'd63);

    // Reset lands on the fourth RUN edge.
    applyStimulus(1'b1, 8'd6, 8'd7, 1'b1);
    stepEdge();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
    repeat (3) stepEdge();
    rst = 1'b1;
    stepEdge();
    rst = 1'b0;
    checkOutput("abort_in_ready", in_ready, 1'b1);
    checkOutput("abort_P", P, 8'd0);
    checkOutput("abort_busy", busy, 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      checkOutput("abort_no_valid", out_valid, 1'b0);
      stepEdge();
    end
    runOne(8'd2, 8'd2, 8'd4, "mul_2x2");

    // in_valid held high: one accept per W+2 edges.
    acc0  = m_accepts;
    dacc0 = dut_accepts;
    applyStimulus(1'b1, 8'd10, 8'd10, 1'b1);
    repeat (3 * (W + 2)) stepEdge();
    checkOutput("b2b_model_accepts", 32'(m_accepts - acc0), 32'd3);
    checkOutput("b2b_dut_accepts", 32'(dut_accepts - dacc0), 32'd3);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
    repeat (2 * W) stepEdge();
    checkOutput("b2b_P", P, 8'd100);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 2) != 0, W'($urandom), W'($urandom),
                    $urandom_range(0, 3) != 0);
      stepEdge();
    end
    rst = 1'b0;

    for (int i = 0; i < 1000 && !w2_done; i++) stepEdge();
    if (!w2_done) checkOutput("width2_sweep_done", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Exhaustive sweep of the two-bit instance.
  initial begin
    rst2       = 1'b1;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    A2         = 2'd0;
    B2         = 2'd0;
    stepEdge();
    stepEdge();
    rst2 = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        in_valid2 = 1'b1;
        A2        = 2'(a);
        B2        = 2'(b);
        stepEdge();
        in_valid2 = 1'b0;
        checkOutput("w2_busy", busy2, 1'b1);
        stepEdge();
        checkOutput("w2_not_early", out_valid2, 1'b0);
        stepEdge();
        checkOutput("w2_valid", out_valid2, 1'b1);
        checkOutput("w2_P", P2, 32'((a * b) % 4));
        stepEdge();
        checkOutput("w2_idle", in_ready2, 1'b1);
      end
    end
    w2_done = 1'b1;
  end

  initial begin
    #1_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and product width in bits; legal range 2..32.
REQ-002 The block SHALL expose these ports:
  clk        input   1      sole clock, rising edge
  rst        input   1      synchronous, active-high reset
  in_valid   input   1      operand pair A/B offered
  in_ready   output  1      block can accept an operand pair
  A          input   WIDTH  multiplicand
  B          input   WIDTH  multiplier
  out_valid  output  1      P holds a completed result
  out_ready  input   1      consumer takes P
  P          output  WIDTH  low WIDTH bits of A*B
  busy       output  1      a multiplication is in progress
REQ-003 The block SHALL use one clock (clk); reset is synchronous and active-high (rst).

Function
REQ-004 The block SHALL compute P = (A*B) mod 2^WIDTH, the truncated low-half product, as an iterative shift-add over WIDTH cycles.
REQ-005 FSM states SHALL be IDLE, RUN and DONE; no other state is reachable.
REQ-006 In IDLE: in_ready=1, busy=0, out_valid=0.
REQ-007 Accept SHALL occur on a rising edge with state==IDLE and in_valid=1.
  - On accept: latch a_reg=A, b_reg=B, acc=0, cnt=0; next state RUN.
REQ-008 A and B SHALL be sampled only at accept; input changes in RUN or DONE have no effect.
REQ-009 Each RUN edge SHALL perform:
  - if b_reg[0]=1: acc = (acc + a_reg) mod 2^WIDTH
  - a_reg <<= 1, dropping the MSB
  - b_reg >>= 1, zero-filled
  - cnt += 1
REQ-010 RUN SHALL last exactly WIDTH edges, with no early termination on b_reg==0.
  - On the edge where cnt==WIDTH-1: next state DONE and P <= final acc.
REQ-011 Latency SHALL be fixed: if accept is on edge k, out_valid=1 after edge k+WIDTH, independent of operand values.
REQ-012 In RUN: in_ready=0, busy=1, out_valid=0. In_valid=1 during RUN SHALL be ignored and SHALL NOT be queued.
REQ-013 In DONE: out_valid=1, busy=0, in_ready=0.
REQ-014 P SHALL be registered and SHALL stay stable from entry into DONE until the output handshake completes.
REQ-015 Output handshake SHALL be out_valid=1 and out_ready=1 on an edge; next state IDLE.
  - out_ready=0 holds DONE indefinitely with P unchanged.
REQ-016 out_ready outside DONE SHALL be ignored.
REQ-017 Back-to-back operation: the earliest next accept is the edge after the output handshake, because in_ready rises in IDLE. Throughput is one result per WIDTH+2 edges at full flow.
REQ-018 P SHALL retain the last result after returning to IDLE until the next DONE entry overwrites it.
REQ-019 cnt width SHALL be clog2(WIDTH)+1, and cnt SHALL NOT wrap within RUN.
REQ-020 in_ready, out_valid and busy SHALL be decoded directly from the state register, with no combinational path from in_valid or out_ready.

Reset
REQ-021 While rst=1 at an edge, the block SHALL set: state=IDLE, P=0, acc=0, a_reg=0, b_reg=0, cnt=0.
  - Resulting outputs: out_valid=0, busy=0, in_ready=1.
REQ-022 rst SHALL take priority over every handshake.
  - Reset during RUN or DONE aborts the operation; no out_valid is produced for it.
  - An in_valid present in the same cycle as rst is not accepted.
REQ-023 The first accept after reset SHALL be possible on the first edge with rst=0.

Verification
REQ-024 WIDTH=8, A=3, B=5, out_ready=1, accept at edge k -> out_valid=1 after edge k+8, P=15; IDLE after edge k+9.
REQ-025 WIDTH=8, A=255, B=255 -> P=1 (65025 mod 256); A=0, B=200 -> P=0 with the same 8-cycle latency.
REQ-026 WIDTH=8, A=7, B=9, out_ready=0 for 5 cycles after DONE entry -> P=63 and out_valid=1 held stable all 5 cycles; A/B toggled meanwhile have no effect; handshake on the 6th cycle returns to IDLE.
REQ-027 WIDTH=8, A=6, B=7, rst=1 at the 4th RUN edge -> next cycle IDLE, in_ready=1, P=0; no out_valid pulse; a new accept A=2, B=2 yields P=4.
REQ-028 WIDTH=8, in_valid held at 1 continuously with A=10, B=10 -> exactly one accept per WIDTH+2 edges; each result is P=100; no accepts while busy=1.
REQ-029 WIDTH=2, all 16 (A,B) pairs -> P equals the low 2 bits of A*B after 2 RUN cycles (e.g. A=3, B=3 -> P=1; A=2, B=3 -> P=2).
